pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives the write-enable and flush inputs of the PC, IF/ID, ID/EX and EX/MEM registers, and selects the next-PC source.
- Resolves load-use hazards, taken branches and jumps, data-memory wait states, and external interrupt entry/exit.
- Sits beside the pipeline registers; fed from ID and EX stage decode.

---
 rtl/pipeline_hazard_ctrl.sv | 173 +++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/next-PC sequencer for a 5-stage MIPS pipeline
module pipeline_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_uses_Rt,
  input  logic             ID_jump,
  input  logic             ID_eret,
  input  logic [31:0]      ID_PC,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_Rt,
  input  logic             EX_branch_taken,
  input  logic             mem_busy,
  input  logic             irq,
  output logic             PC_write,
  output logic             IFID_write,
  output logic             IDEX_write,
  output logic             EXMEM_write,
  output logic             IFID_flush,
  output logic             IDEX_flush,
  output logic [1:0]       PC_sel,
  output logic             irq_ack,
  output logic             in_handler,
  output logic [31:0]      EPC,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_IRQ_DRAIN  = 2'd1,
    ST_IRQ_VECTOR = 2'd2
  } state_t;

  state_t            state_q;
  logic [2:0]        drain_q;
  logic [31:0]       epc_q;
  logic              in_handler_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  stall_cnt_d;

  logic load_use;
  logic accept_irq;
  logic eret_clear;

  // A load in EX whose destination is read by ID forces a one-cycle bubble; $zero never conflicts.
  assign load_use = EX_MemRead && (EX_Rt != 5'd0) &&
                    ((EX_Rt == ID_Rs) || (ID_uses_Rt && (EX_Rt == ID_Rt)));

  assign in_handler = in_handler_q;
  assign EPC        = epc_q;
  assign stall_cnt  = stall_cnt_q;

  // Pipeline enables, flushes and PC source decoded from the current state and stage inputs.
  always_comb begin
    PC_write    = 1'b1;
    IFID_write  = 1'b1;
    IDEX_write  = 1'b1;
    EXMEM_write = 1'b1;
    IFID_flush  = 1'b0;
    IDEX_flush  = 1'b0;
    PC_sel      = 2'd0;
    irq_ack     = 1'b0;
    accept_irq  = 1'b0;
    eret_clear  = 1'b0;

    if (reset) begin
      PC_write    = 1'b0;
      IFID_write  = 1'b0;
      IDEX_write  = 1'b0;
      EXMEM_write = 1'b0;
    end else if (mem_busy) begin
      // A data-memory wait freezes every stage whatever the state.
      PC_write    = 1'b0;
      IFID_write  = 1'b0;
      IDEX_write  = 1'b0;
      EXMEM_write = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (irq && !in_handler_q && !EX_branch_taken && !ID_jump) begin
            // A pending redirect defers the interrupt so EPC never points at a squashed path.
            accept_irq = 1'b1;
            PC_write   = 1'b0;
            IFID_flush = 1'b1;
            IDEX_flush = 1'b1;
          end else if (EX_branch_taken) begin
            PC_sel     = 2'd1;
            IFID_flush = 1'b1;
            IDEX_flush = 1'b1;
          end else if (ID_jump) begin
            PC_sel     = 2'd2;
            IFID_flush = 1'b1;
          end else if (load_use) begin
            PC_write   = 1'b0;
            IFID_write = 1'b0;
            IDEX_flush = 1'b1;
          end else if (ID_eret) begin
            eret_clear = 1'b1;
          end
        end
        ST_IRQ_DRAIN: begin
          // Front end held with bubbles while EX/MEM and MEM/WB retire.
          PC_write   = 1'b0;
          IFID_flush = 1'b1;
          IDEX_flush = 1'b1;
        end
        ST_IRQ_VECTOR: begin
          PC_sel     = 2'd3;
          IFID_flush = 1'b1;
          irq_ack    = 1'b1;
        end
        default: begin
          PC_write = 1'b1;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC did not advance.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!PC_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Interrupt entry sequencer, EPC capture, handler mask and stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RUN;
      drain_q      <= 3'd0;
      epc_q        <= 32'd0;
      in_handler_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      case (state_q)
        ST_RUN: begin
          if (accept_irq) begin
            epc_q   <= ID_PC;
            drain_q <= 3'(DRAIN_CYCLES - 1);
            state_q <= ST_IRQ_DRAIN;
          end else if (eret_clear) begin
            in_handler_q <= 1'b0;
          end
        end
        ST_IRQ_DRAIN: begin
          if (!mem_busy) begin
            if (drain_q == 3'd0) begin
              state_q <= ST_IRQ_VECTOR;
            end else begin
              drain_q <= drain_q - 3'd1;
            end
          end
        end
        ST_IRQ_VECTOR: begin
          if (!mem_busy) begin
            in_handler_q <= 1'b1;
            state_q      <= ST_RUN;
          end
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  localparam int DRAIN = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ID_Rs, ID_Rt, EX_Rt;
  logic        ID_uses_Rt, ID_jump, ID_eret, EX_MemRead, EX_branch_taken, mem_busy, irq;
  logic [31:0] ID_PC;

  logic        PC_write, IFID_write, IDEX_write, EXMEM_write, IFID_flush, IDEX_flush, irq_ack, in_handler;
  logic [1:0]  PC_sel;
  logic [31:0] EPC;
  logic [15:0] stall_cnt;

  logic        s_PC_write, s_IFID_write, s_IDEX_write, s_EXMEM_write, s_IFID_flush, s_IDEX_flush, s_irq_ack, s_in_handler;
  logic [1:0]  s_PC_sel;
  logic [31:0] s_EPC;
  logic [3:0]  s_stall_cnt;

  int checks = 0;
  int failures = 0;

  // reference model state
  bit          m_handler;
  bit          m_entering;
  int          m_drain_left;
  logic [31:0] m_epc;
  int          m_stalls;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_uses_Rt(ID_uses_Rt),
    .ID_jump(ID_jump), .ID_eret(ID_eret), .ID_PC(ID_PC), .EX_MemRead(EX_MemRead),
    .EX_Rt(EX_Rt), .EX_branch_taken(EX_branch_taken), .mem_busy(mem_busy), .irq(irq),
    .PC_write(PC_write), .IFID_write(IFID_write), .IDEX_write(IDEX_write),
    .EXMEM_write(EXMEM_write), .IFID_flush(IFID_flush), .IDEX_flush(IDEX_flush),
    .PC_sel(PC_sel), .irq_ack(irq_ack), .in_handler(in_handler), .EPC(EPC),
    .stall_cnt(stall_cnt)
  );

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_uses_Rt(ID_uses_Rt),
    .ID_jump(ID_jump), .ID_eret(ID_eret), .ID_PC(ID_PC), .EX_MemRead(EX_MemRead),
    .EX_Rt(EX_Rt), .EX_branch_taken(EX_branch_taken), .mem_busy(mem_busy), .irq(irq),
    .PC_write(s_PC_write), .IFID_write(s_IFID_write), .IDEX_write(s_IDEX_write),
    .EXMEM_write(s_EXMEM_write), .IFID_flush(s_IFID_flush), .IDEX_flush(s_IDEX_flush),
    .PC_sel(s_PC_sel), .irq_ack(s_irq_ack), .in_handler(s_in_handler), .EPC(s_EPC),
    .stall_cnt(s_stall_cnt)
  );

  // {PC_write, IFID_write, IDEX_write, EXMEM_write, IFID_flush, IDEX_flush, PC_sel, irq_ack}
  wire [8:0] outs = {PC_write, IFID_write, IDEX_write, EXMEM_write, IFID_flush, IDEX_flush, PC_sel, irq_ack};

  localparam logic [8:0] O_IDLE   = 9'b111100000;
  localparam logic [8:0] O_FROZEN = 9'b000000000;
  localparam logic [8:0] O_LDUSE  = 9'b001101000;
  localparam logic [8:0] O_HOLDFE = 9'b011111000;
  localparam logic [8:0] O_BRANCH = 9'b111111010;
  localparam logic [8:0] O_JUMP   = 9'b111110100;
  localparam logic [8:0] O_VECTOR = 9'b111110111;

  function automatic bit model_hazard();
    return EX_MemRead && EX_Rt != 0 && (EX_Rt == ID_Rs || (ID_uses_Rt && EX_Rt == ID_Rt));
  endfunction

  function automatic bit model_take_irq();
    return !m_entering && irq && !m_handler && !EX_branch_taken && !ID_jump;
  endfunction

  function automatic logic [8:0] model_out();
    if (reset || mem_busy) return O_FROZEN;
    if (m_entering) return (m_drain_left > 0) ? O_HOLDFE : O_VECTOR;
    if (model_take_irq()) return O_HOLDFE;
    if (EX_branch_taken) return O_BRANCH;
    if (ID_jump) return O_JUMP;
    if (model_hazard()) return O_LDUSE;
    return O_IDLE;
  endfunction

  task automatic tick();
    logic [8:0] e;
    e = model_out();
    @(posedge clk);
    if (reset) begin
      m_handler = 0; m_entering = 0; m_drain_left = 0; m_epc = 0; m_stalls = 0;
    end else begin
      if (e[8] == 1'b0) m_stalls++;
      if (!mem_busy) begin
        if (m_entering) begin
          if (m_drain_left > 0) m_drain_left--;
          else begin m_entering = 0; m_handler = 1; end
        end else if (model_take_irq()) begin
          m_epc = ID_PC; m_entering = 1; m_drain_left = DRAIN;
        end else if (ID_eret && !EX_branch_taken && !ID_jump && !model_hazard()) begin
          m_handler = 0;
        end
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    ID_Rs = 0; ID_Rt = 0; ID_uses_Rt = 0; ID_jump = 0; ID_eret = 0; ID_PC = 32'h0040_0000;
    EX_MemRead = 0; EX_Rt = 0; EX_branch_taken = 0; mem_busy = 0; irq = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1; tick(); reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; irq = 1; EX_branch_taken = 1;
    tick();
    @(negedge clk);
    checks++; if (outs !== O_FROZEN) begin failures++; $display("FAIL reset_outs got=%b exp=%b", outs, O_FROZEN); end
    checks++; if ({in_handler, EPC, stall_cnt} !== 49'd0) begin failures++; $display("FAIL reset_state got=%b/%h/%0d exp=0/0/0", in_handler, EPC, stall_cnt); end
    tick(); reset = 0; idle_inputs();
    @(negedge clk);
    checks++; if (outs !== O_IDLE) begin failures++; $display("FAIL post_reset_outs got=%b exp=%b", outs, O_IDLE); end
  endtask

  task automatic test_load_use();
    do_reset();
    EX_MemRead = 1; EX_Rt = 8; ID_Rs = 8;
    @(negedge clk);
    checks++; if (outs !== O_LDUSE) begin failures++; $display("FAIL load_use_rs got=%b exp=%b", outs, O_LDUSE); end
    tick();
    checks++; if (stall_cnt !== 16'd1) begin failures++; $display("FAIL load_use_cnt got=%0d exp=1", stall_cnt); end
    EX_Rt = 0; ID_Rs = 0;
    @(negedge clk);
    checks++; if (outs !== O_IDLE) begin failures++; $display("FAIL load_use_r0 got=%b exp=%b", outs, O_IDLE); end
    tick();
    checks++; if (stall_cnt !== 16'd1) begin failures++; $display("FAIL load_use_r0_cnt got=%0d exp=1", stall_cnt); end
  endtask

  task automatic test_rt_gating();
    do_reset();
    EX_MemRead = 1; EX_Rt = 9; ID_Rt = 9; ID_Rs = 3; ID_uses_Rt = 0;
    @(negedge clk);
    checks++; if (outs !== O_IDLE) begin failures++; $display("FAIL rt_unused got=%b exp=%b", outs, O_IDLE); end
    tick();
    ID_uses_Rt = 1;
    @(negedge clk);
    checks++; if (outs !== O_LDUSE) begin failures++; $display("FAIL rt_used got=%b exp=%b", outs, O_LDUSE); end
    tick();
  endtask

  task automatic test_branch_irq();
    do_reset();
    EX_branch_taken = 1; ID_jump = 1; irq = 1; ID_PC = 32'h0040_0100;
    @(negedge clk);
    checks++; if (outs !== O_BRANCH) begin failures++; $display("FAIL redirect_wins got=%b exp=%b", outs, O_BRANCH); end
    tick();
    EX_branch_taken = 0; ID_jump = 0; ID_PC = 32'h0040_0200;
    @(negedge clk);
    checks++; if (outs !== O_HOLDFE) begin failures++; $display("FAIL deferred_accept got=%b exp=%b", outs, O_HOLDFE); end
    tick();
    checks++; if (EPC !== 32'h0040_0200) begin failures++; $display("FAIL deferred_epc got=%h exp=00400200", EPC); end
  endtask

  task automatic test_irq_entry();
    do_reset();
    irq = 1; ID_PC = 32'h0040_0010;
    @(negedge clk);
    checks++; if (outs !== O_HOLDFE) begin failures++; $display("FAIL entry_accept got=%b exp=%b", outs, O_HOLDFE); end
    tick();
    checks++; if (EPC !== 32'h0040_0010) begin failures++; $display("FAIL entry_epc got=%h exp=00400010", EPC); end
    for (int k = 0; k < DRAIN; k++) begin
      @(negedge clk);
      checks++; if (outs !== O_HOLDFE) begin failures++; $display("FAIL entry_drain%0d got=%b exp=%b", k, outs, O_HOLDFE); end
      tick();
    end
    @(negedge clk);
    checks++; if (outs !== O_VECTOR) begin failures++; $display("FAIL entry_vector got=%b exp=%b", outs, O_VECTOR); end
    checks++; if (stall_cnt !== 16'd3) begin failures++; $display("FAIL entry_stalls got=%0d exp=3", stall_cnt); end
    tick();
    checks++; if (in_handler !== 1'b1) begin failures++; $display("FAIL entry_masked got=%b exp=1", in_handler); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (outs !== O_IDLE) begin failures++; $display("FAIL no_reentry%0d got=%b exp=%b", k, outs, O_IDLE); end
      tick();
    end
    ID_eret = 1;
    tick();
    ID_eret = 0;
    checks++; if (in_handler !== 1'b0) begin failures++; $display("FAIL eret_unmask got=%b exp=0", in_handler); end
    @(negedge clk);
    checks++; if (outs !== O_HOLDFE) begin failures++; $display("FAIL reentry_after_eret got=%b exp=%b", outs, O_HOLDFE); end
    tick();
  endtask

  task automatic test_drain_busy();
    int ack_cycle;
    do_reset();
    irq = 1; ID_PC = 32'h0040_0400;
    tick();
    irq = 0;
    ack_cycle = -1;
    for (int c = 1; c <= 20 && ack_cycle < 0; c++) begin
      mem_busy = (c >= 2 && c <= 4);
      @(negedge clk);
      if (mem_busy) begin
        checks++; if (outs !== O_FROZEN) begin failures++; $display("FAIL drain_busy_freeze c=%0d got=%b exp=%b", c, outs, O_FROZEN); end
      end
      if (irq_ack === 1'b1) ack_cycle = c;
      tick();
    end
    mem_busy = 0;
    checks++; if (ack_cycle != 6) begin failures++; $display("FAIL drain_busy_delay got=%0d exp=6", ack_cycle); end
  endtask

  task automatic test_reset_mid_drain();
    bit saw_ack;
    do_reset();
    irq = 1; ID_PC = 32'h0040_0800;
    tick(); tick();
    irq = 0; reset = 1;
    @(negedge clk);
    checks++; if (outs !== O_FROZEN) begin failures++; $display("FAIL midreset_outs got=%b exp=%b", outs, O_FROZEN); end
    tick(); reset = 0;
    checks++; if ({in_handler, EPC, stall_cnt} !== 49'd0) begin failures++; $display("FAIL midreset_state got=%b/%h/%0d exp=0/0/0", in_handler, EPC, stall_cnt); end
    saw_ack = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (irq_ack === 1'b1 || PC_write !== 1'b1) saw_ack = 1;
      tick();
    end
    checks++; if (saw_ack) begin failures++; $display("FAIL midreset_resume got=ack_or_stall exp=idle_run"); end
  endtask

  task automatic test_saturation();
    do_reset();
    EX_MemRead = 1; EX_Rt = 5; ID_Rs = 5;
    for (int c = 0; c < 20; c++) tick();
    idle_inputs();
    @(negedge clk);
    checks++; if (s_stall_cnt !== 4'd15) begin failures++; $display("FAIL sat_cnt got=%0d exp=15", s_stall_cnt); end
    checks++; if (stall_cnt !== 16'd20) begin failures++; $display("FAIL wide_cnt got=%0d exp=20", stall_cnt); end
  endtask

  task automatic test_random();
    logic [8:0] e;
    int bad;
    do_reset();
    bad = 0;
    for (int c = 0; c < 3000; c++) begin
      reset           = ($urandom_range(0, 199) == 0);
      ID_Rs           = 5'($urandom_range(0, 3));
      ID_Rt           = 5'($urandom_range(0, 3));
      EX_Rt           = 5'($urandom_range(0, 3));
      ID_uses_Rt      = 1'($urandom_range(0, 1));
      EX_MemRead      = ($urandom_range(0, 2) == 0);
      ID_jump         = ($urandom_range(0, 6) == 0);
      EX_branch_taken = ($urandom_range(0, 6) == 0);
      ID_eret         = ($urandom_range(0, 9) == 0);
      mem_busy        = ($urandom_range(0, 4) == 0);
      irq             = ($urandom_range(0, 3) == 0);
      ID_PC           = $urandom;
      @(negedge clk);
      e = model_out();
      checks++;
      if (outs !== e || in_handler !== m_handler || EPC !== m_epc ||
          stall_cnt !== 16'((m_stalls > 65535) ? 65535 : m_stalls) ||
          s_stall_cnt !== 4'((m_stalls > 15) ? 15 : m_stalls)) begin
        failures++;
        if (bad < 10) $display("FAIL random c=%0d outs=%b/%b hnd=%b/%b epc=%h/%h cnt=%0d/%0d sat=%0d", c, outs, e,
                               in_handler, m_handler, EPC, m_epc, stall_cnt, m_stalls, s_stall_cnt);
        bad++;
      end
      tick();
    end
    reset = 0;
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    m_handler = 0; m_entering = 0; m_drain_left = 0; m_epc = 0; m_stalls = 0;
    #1;
    test_reset();
    test_load_use();
    test_rt_gating();
    test_branch_irq();
    test_irq_entry();
    test_drain_busy();
    test_reset_mid_drain();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
